// File: rtl/clock_ctrl_if.sv
// Purpose : board-side signal bundle of the clock controller (buttons, counter carries, CE/mode/blink).
// Latency : wiring only; no storage.
// Backpres: none; all signals are level/strobe, no handshake.
//
// Ports (master = board/counter side, slave = clock_ctrl):
//   mode_btn, inc_btn     raw asynchronous push-buttons, active-high
//   sec_carry, min_carry  carry outputs of the seconds / minutes mod-60 chains
//   ce_sec, ce_min, ce_hr clock-enables to the seconds / minutes / hours chains
//   mode                  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC
//   blink                 field-blank strobe for the selected field
interface clock_ctrl_if;
    logic       mode_btn;
    logic       inc_btn;
    logic       sec_carry;
    logic       min_carry;
    logic       ce_sec;
    logic       ce_min;
    logic       ce_hr;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output mode_btn, inc_btn, sec_carry, min_carry,
        input  ce_sec, ce_min, ce_hr, mode, blink
    );

    modport slave (
        input  mode_btn, inc_btn, sec_carry, min_carry,
        output ce_sec, ce_min, ce_hr, mode, blink
    );
endinterface

// File: rtl/clock_ctrl.sv
// Purpose : RUN/SET mode controller for a digital clock: 1 Hz prescaler, button debounce, CE steering.
// Latency : button press strobe one cycle after edge DB_CYCLES+2; tick every TICK_DIV cycles; CE combinational.
// Backpres: none; the counter chains advance on every CE cycle, carries are consumed in the same cycle.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   ctrl   clock_ctrl_if.slave: buttons and carries in; ce_sec/ce_min/ce_hr, mode, blink out
module clock_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 500000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic         clk,
    input  logic         reset,
    clock_ctrl_if.slave  ctrl
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DB_CYCLES);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST    = DW'(DB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Button index 0 is the mode button, index 1 the increment button.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    level_d;
    logic [1:0]    press;
    logic [DW-1:0] db_cnt [2];

    mode_t         mode_q;
    logic [TW-1:0] presc;
    logic          tick;
    logic [BW-1:0] blink_cnt;
    logic          blink_q;

    logic          mode_press;
    logic          inc_press;
    logic          inc_hit;
    logic          run;

    // ------------------------------------------------------------------
    // Button synchronizer + debounce + rising-edge strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            press   <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= {ctrl.inc_btn, ctrl.mode_btn};
            sync2   <= sync1;
            level_d <= level;
            // Strobe one cycle after the accepted level rises; release is silent.
            press   <= level & ~level_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    // Any agreement restarts the count, so glitches must settle again.
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign mode_press = press[0];
    assign inc_press  = press[1];

    // ------------------------------------------------------------------
    // Mode FSM, prescaler and blink generator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= RUN;
            presc     <= '0;
            tick      <= 1'b0;
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else begin
            tick <= 1'b0;

            if (mode_press) begin
                case (mode_q)
                    RUN:     mode_q <= SET_HR;
                    SET_HR:  mode_q <= SET_MIN;
                    SET_MIN: mode_q <= SET_SEC;
                    default: mode_q <= RUN;
                endcase
            end

            // Prescaler follows the current state; held at 0 while setting so
            // the first tick after returning to RUN is a full period away.
            if (mode_q == RUN) begin
                if (presc == TICK_LAST) begin
                    presc <= '0;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                presc <= '0;
            end

            // Every state change restarts the blink phase from dark-off.
            if (mode_press || mode_q == RUN) begin
                blink_cnt <= '0;
                blink_q   <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // CE steering. A simultaneous mode press wins and swallows the inc press,
    // otherwise the inc would land in the field being left.
    // ------------------------------------------------------------------
    assign run     = (mode_q == RUN);
    assign inc_hit = inc_press & ~mode_press;

    assign ctrl.ce_sec = (run & tick)           | ((mode_q == SET_SEC) & inc_hit);
    assign ctrl.ce_min = (run & ctrl.sec_carry) | ((mode_q == SET_MIN) & inc_hit);
    assign ctrl.ce_hr  = (run & ctrl.min_carry) | ((mode_q == SET_HR)  & inc_hit);
    assign ctrl.mode   = mode_q;
    assign ctrl.blink  = blink_q;

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Mode and time-set controller for the digital-clock datapath, which is built from cascaded mod-60/mod-24 counter chains with clock-enable inputs and carry outputs.
- Generates the 1 Hz count strobe and debounces the two user push-buttons.
- Runs a RUN/SET mode FSM and steers the CE of the seconds, minutes and hours chains.
- Sits between the board buttons and the counter chains; the counters hold all time state, and this block only decides when each one advances.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 Hz tick (≥2).
- DB_CYCLES, 500000, cycles a synchronized button level must persist before it is accepted (≥2).
- BLINK_DIV, 12500000, cycles between blink toggles in set modes (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode_btn  in  1  raw mode push-button, asynchronous, active-high.
- inc_btn  in  1  raw increment push-button, asynchronous, active-high.
- sec_carry  in  1  carry out (CEO2) of the seconds mod-60 chain.
- min_carry  in  1  carry out (CEO2) of the minutes mod-60 chain.
- ce_sec  out  1  CE to the seconds chain.
- ce_min  out  1  CE to the minutes chain.
- ce_hr  out  1  CE to the hours chain.
- mode  out  2  current FSM state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
- blink  out  1  field-blank strobe for the display; the selected field is blanked while blink=1.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - mode=RUN; prescaler=0; tick=0; blink=0; blink counter=0.
  - Both synchronizer stages, debounce counters, accepted levels and press strobes = 0.
  - Reset overrides all other activity, mid-press or mid-count.
- Button path, identical for each button:
  - Two-FF synchronizer s1→s2.
  - On each edge where s2 ≠ accepted level, the debounce counter increments. When the counter equals DB_CYCLES-1 and s2 still differs, the accepted level takes s2 and the counter clears.
  - On any edge where s2 = accepted level, the counter clears, so glitches restart the count.
  - The press strobe is registered: 1 for exactly one cycle after a 0→1 change of the accepted level.
  - Latency: a raw input first sampled 1 at edge 0 and held gives press=1 in the cycle after edge DB_CYCLES+2.
  - Release produces no strobe.
  - A button held through reset release is accepted as a new press after the debounce delay.
- Mode FSM (advances only on mode press):
  - RUN→SET_HR→SET_MIN→SET_SEC→RUN.
  - If mode and inc presses occur in the same cycle, the mode transition happens and the inc press is discarded.
- Prescaler:
  - In RUN it counts 0..TICK_DIV-1. On the edge where it equals TICK_DIV-1, it goes to 0 and the registered tick goes to 1 for one cycle; otherwise tick=0.
  - In any SET state the prescaler is held at 0 and tick=0.
  - After reset, and after the SET_SEC→RUN transition, the first tick is high in the cycle after the TICK_DIV-th edge. The period is then exactly TICK_DIV.
- CE outputs are combinational from registered state and strobes plus the carry inputs:
  - ce_sec = (RUN & tick) | (SET_SEC & inc_press).
  - ce_min = (RUN & sec_carry) | (SET_MIN & inc_press).
  - ce_hr = (RUN & min_carry) | (SET_HR & inc_press).
  - In SET states the carry inputs are ignored, so incrementing one field never ripples into another.
  - At most one inc-driven CE is active per press.
- Blink:
  - In SET states, a counter counts 0..BLINK_DIV-1 and blink toggles on the edge where the count equals BLINK_DIV-1.
  - On entry to RUN, blink is forced 0 and the counter is cleared.
  - Each SET-state entry starts from blink=0 and counter=0.
- No other state is held. Counter wrap-around (59→0, 23→0) is entirely the counters' responsibility.

Test Plan (TICK_DIV=10, DB_CYCLES=4, BLINK_DIV=3):
- Timing: release reset, hold buttons low, carries 0 → ce_sec pulses one cycle every 10 cycles, first after edge 10. ce_min=ce_hr=0, mode=0, blink=0.
- Carry chain: in RUN, drive sec_carry=1 only while ce_sec=1 → ce_min equals ce_sec in that cycle. min_carry=1 → ce_hr=1 in the same cycle.
- Debounce:
  - mode_btn high for 3 cycles, then low → no press, mode stays 0.
  - Held for 20 cycles → single press in the cycle after edge 6; mode=1 for the rest of the hold.
  - Bounce 1,0,1,1,1,1,1 → press is delayed past the glitch.
- Set sequence:
  - One mode press → mode=1. Two inc presses → exactly two one-cycle ce_hr pulses; ce_sec=ce_min=0, and carries driven high are ignored.
  - Mode press → mode=2, and inc gives ce_min. Mode press → mode=3, and inc gives ce_sec.
  - Mode press → mode=0, and the first tick comes 10 cycles later.
- Simultaneous presses and blink:
  - mode_btn and inc_btn rise together in SET_HR → mode=2, no ce_hr pulse.
  - In SET states blink toggles every 3 cycles; it drops to 0 on return to RUN.
- Reset mid-operation: assert reset in SET_MIN with blink=1 and a debounce in progress → next cycle mode=0, blink=0, all CE=0, and the prescaler restarts so the first tick comes 10 cycles after reset release.
